// File: rtl/logic_op_pkg.sv
// Shared definitions for the pipelined bitwise logic-function block:
// the op-select field width and the eight function codes.
package logic_op_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_stage.sv
// One valid/data register slice. Loads when empty or when its current contents
// leave in the same cycle; ready ripples combinationally from downstream.
module logic_op_stage #(
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    load       = in_valid_i && in_ready_o;
    valid_d    = valid_q;
    data_d     = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined bitwise logic unit: per-transaction function select, STAGES-deep
// valid/ready pipeline carrying result plus zero/ones flags, saturating counter.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned DW = WIDTH + 2;

  logic [WIDTH-1:0] res;
  logic             res_zero, res_ones;

  always_comb begin
    res = a;
    case (op_e'(op))
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_PASS: res = a;
      default: res = a;
    endcase
    res_zero = ~|res;
    res_ones = &res;
  end

  // Flags travel with the data so they stay aligned under backpressure.
  logic [STAGES:0] st_valid;
  logic [STAGES:0] st_ready;
  logic [DW-1:0]   st_data [STAGES+1];

  assign st_valid[0]      = in_valid;
  assign st_data[0]       = {res_ones, res_zero, res};
  assign st_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_op_stage #(
      .DW(DW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (st_valid[k]),
      .in_data_i   (st_data[k]),
      .in_ready_o  (st_ready[k]),
      .out_valid_o (st_valid[k+1]),
      .out_data_o  (st_data[k+1]),
      .out_ready_i (st_ready[k+1])
    );
  end

  // Empty slices would report ready during reset; hold the source off instead.
  assign in_ready  = rst_n && st_ready[0];
  assign out_valid = st_valid[STAGES];
  assign {ones, zero, y} = st_data[STAGES];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept = in_valid && in_ready;
    cnt_d  = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench: accepted transactions are pushed with their truth-table
// result; an output monitor pops and compares on every output transfer.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_ready_s;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       out_valid, out_valid_s, out_ready;
  logic [7:0] y, y_s;
  logic       zero, ones, zero_s, ones_s;
  logic [15:0] xfer_cnt;
  logic [2:0]  xfer_cnt_s;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned acc   = 0;
  int unsigned acc_s = 0;
  logic [9:0]  sb [$];
  logic [9:0]  exp_e;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .xfer_cnt(xfer_cnt)
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .zero(zero_s), .ones(ones_s), .xfer_cnt(xfer_cnt_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth table per op, indexed by {a_bit, b_bit}.
  function automatic logic [3:0] tt(input logic [2:0] o);
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
  endfunction

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [3:0] t;
    logic [7:0] r;
    t = tt(o);
    for (int i = 0; i < 8; i++) r[i] = t[{x[i], z[i]}];
    return r;
  endfunction

  function automatic logic [9:0] ref_pack(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    r = ref_y(o, x, z);
    return {r == 8'hFF, r == 8'h00, r};
  endfunction

  // Input side: counter checks, then record accepted transactions.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("xfer_cnt", 64'(xfer_cnt), 64'((acc > 65535) ? 65535 : acc));
      chk("xfer_cnt_sat", 64'(xfer_cnt_s), 64'((acc_s > 7) ? 7 : acc_s));
      if (in_valid && in_ready) begin
        acc++;
        sb.push_back(ref_pack(op, a, b));
      end
      if (in_valid && in_ready_s) acc_s++;
    end
  end

  // Output side: every output transfer must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(1), 64'(0));
      end else begin
        exp_e = sb.pop_front();
        chk("sb_y", 64'(y), 64'(exp_e[7:0]));
        chk("sb_zero", 64'(zero), 64'(exp_e[8]));
        chk("sb_ones", 64'(ones), 64'(exp_e[9]));
        chk("sat_valid", 64'(out_valid_s), 64'(1));
        chk("sat_y", 64'(y_s), 64'(exp_e[7:0]));
        chk("sat_flags", 64'({ones_s, zero_s}), 64'(exp_e[9:8]));
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
    bit done = 1'b0;
    in_valid = 1'b1; op = o; a = xa; b = xb;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sweep [8];
    logic [7:0] first_y;
    sweep = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h3C, 8'hC3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_flags", 64'({ones, zero}), 64'(0));
    chk("rst_cnt", 64'(xfer_cnt), 64'(0));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Op sweep, back-to-back, out_ready held high.
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hC3; b = 8'h5A;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) op = 3'(i);
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (i == 0) chk("first_latency", 64'(out_valid), 64'(0));
      else begin
        chk("sweep_valid", 64'(out_valid), 64'(1));
        chk("sweep_y", 64'(y), 64'(sweep[i-1]));
      end
    end
    chk("sweep_cnt", 64'(xfer_cnt), 64'(8));
    idle(3);

    // Flags.
    send(3'd0, 8'hF0, 8'h0F);
    send(3'd1, 8'hF0, 8'h0F);
    in_valid = 1'b0;
    chk("flag_and_y", 64'({ones, zero, y}), 64'({1'b0, 1'b1, 8'h00}));
    @(posedge clk); #1;
    chk("flag_or_y", 64'({ones, zero, y}), 64'({1'b1, 1'b0, 8'hFF}));
    idle(3);

    // Backpressure: two accepts fill the pipe, output holds.
    out_ready = 1'b0;
    send(3'd2, 8'h12, 8'h34);
    send(3'd0, 8'hAB, 8'hCD);
    in_valid = 1'b1; op = 3'd4; a = 8'h0F; b = 8'h11;
    first_y = ref_y(3'd2, 8'h12, 8'h34);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_y", 64'(y), 64'(first_y));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd4, 8'h0F, 8'h11);
    send(3'd5, 8'h77, 8'h70);
    idle(4);

    // Full pipe with out_ready high keeps accepting every cycle.
    out_ready = 1'b0;
    send(3'd1, 8'h01, 8'h02);
    send(3'd3, 8'h03, 8'h04);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      #1;
      chk("full_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    idle(4);

    // Reset with two items in flight.
    out_ready = 1'b0;
    send(3'd6, 8'h5A, 8'h00);
    send(3'd7, 8'hA5, 8'h00);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    acc = 0; acc_s = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_y", 64'(y), 64'(0));
    chk("mid_rst_cnt", 64'(xfer_cnt), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #4;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_stale_out", 64'(out_valid), 64'(0));
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      op        = 3'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    idle(8);
    chk("drain_empty", 64'(sb.size()), 64'(0));
    chk("final_sat_cnt", 64'(xfer_cnt_s), 64'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
